// File: rtl/spi_shift_engine.sv
// SPI master shift engine: chip-select sequencing, SCLK edge tracking and MOSI/MISO shifting.
// Define SPI_LSB_FIRST_EN to add the lsb_first input and LSB-first bit ordering.
module spi_shift_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              spi_clk,
  output logic              clk_gen_en,
  input  logic              miso,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NumEdges = 2 * DATA_W;
  localparam int unsigned CntW     = $clog2(NumEdges + 1);
  localparam int unsigned TmrMax   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned TmrW     = (TmrMax > 1) ? $clog2(TmrMax) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q;
  logic [CntW-1:0]   edge_cnt_q;
  logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
  logic [DATA_W-1:0] tx_load, rx_shift;
  logic              sclk_q, cpol_q, cpha_q, mosi_q, cs_n_q, lsb_q;
  logic              start_ok, sclk_edge, lead_edge, trail_edge, last_edge;
  logic              sample_edge, shift_edge;

  assign start_ok = (state_q == StIdle) && start;

`ifdef SPI_LSB_FIRST_EN
  // LSB-first transmit is a bit-reversed frame pushed through the MSB-first shifter.
  assign tx_load = lsb_first ? {<<{tx_data}} : tx_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      lsb_q <= 1'b0;
    end else if (start_ok) begin
      lsb_q <= lsb_first;
    end
  end
`else
  assign tx_load = tx_data;
  assign lsb_q   = 1'b0;
`endif

  assign rx_shift = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};

  assign sclk_edge  = (state_q == StXfer) && (spi_clk != sclk_q);
  assign lead_edge  = sclk_edge && (spi_clk != cpol_q);
  assign trail_edge = sclk_edge && (spi_clk == cpol_q);
  assign last_edge  = sclk_edge && (edge_cnt_q == CntW'(NumEdges - 1));

  // cpha=0 samples on leading and shifts on trailing; cpha=1 is the reverse.
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : (trail_edge && !last_edge);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StSetup;
      StSetup: if (tmr_q == TmrW'(CS_SETUP - 1)) state_d = StXfer;
      StXfer:  if (last_edge) state_d = StHold;
      StHold:  if (tmr_q == TmrW'(CS_HOLD - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clk_gen_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      StSetup, StHold: busy = 1'b1;
      StXfer: begin
        busy       = 1'b1;
        clk_gen_en = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      // The generator idles at the new cpol from the start edge on, so track that level.
      sclk_q <= start_ok ? cpol : spi_clk;
      tmr_q  <= (state_d != state_q) ? '0 : tmr_q + TmrW'(1);

      if ((state_d == StXfer) && (state_q != StXfer)) begin
        edge_cnt_q <= '0;
      end else if (sclk_edge && (edge_cnt_q != CntW'(NumEdges))) begin
        edge_cnt_q <= edge_cnt_q + CntW'(1);
      end

      if (start_ok) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        rx_sr_q <= '0;
        cs_n_q  <= 1'b0;
        // cpha=0 drives the first bit right away, so its shifter starts one bit ahead.
        mosi_q  <= cpha ? 1'b0 : tx_load[DATA_W-1];
        tx_sr_q <= cpha ? tx_load : {tx_load[DATA_W-2:0], 1'b0};
      end

      if (shift_edge) begin
        mosi_q  <= tx_sr_q[DATA_W-1];
        tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
      end

      if (sample_edge) begin
        rx_sr_q <= rx_shift;
      end

      if (state_d == StDone) begin
        mosi_q    <= 1'b0;
        rx_data_q <= rx_sr_q;
      end

      if (state_q == StDone) begin
        cs_n_q <= 1'b1;
      end
    end
  end

  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;
  assign rx_data = rx_data_q;

endmodule
